// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_seq_pkg
//  Purpose  : Shared state encoding and default constants for pc_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pc_seq_state_t;

    // Word address holding 32'h0, fetched whenever nothing real should issue
    localparam logic [31:0] c_NOP_ADDR     = 32'h0000_03FC;
    localparam int          c_DRAIN_CYCLES = 4;
    localparam logic [31:0] c_MAX_CYCLES   = 32'd100000;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Clearable up-counter that sticks at all-ones instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Drives the core fetch port through a program, drains the
//             pipeline with NOPs, and reports completion/timeout/perf counts.
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] NOP_ADDR     = ADDR_W'(c_NOP_ADDR),
    parameter int                DRAIN_CYCLES = c_DRAIN_CYCLES,
    parameter logic [31:0]       MAX_CYCLES   = c_MAX_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              PC_Write,
    input  logic [ADDR_W-1:0] Output_Addr,
    output logic [ADDR_W-1:0] Input_Addr,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycle_count,
    output logic [31:0]       instr_count,
    output logic [31:0]       stall_count
);

    localparam int c_DW = $clog2(DRAIN_CYCLES + 1);

    pc_seq_state_t     r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_end_addr;
    logic [c_DW-1:0]   r_drain_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;

    logic              w_active;
    logic              w_accept;
    logic              w_expired;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_end;

    assign w_active  = (r_state == RUN) || (r_state == DRAIN);
    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_expired = w_active && (cycle_count == (MAX_CYCLES - 32'd1));
    assign w_base    = base_addr & ~ADDR_W'(3);
    assign w_end     = end_addr  & ~ADDR_W'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_end_addr  <= '0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_pc       <= w_base;
                        r_end_addr <= w_end;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_timeout  <= 1'b0;
                        if (w_base == w_end) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= c_DW'(DRAIN_CYCLES);
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Budget expiry overrides the end-address exit on the same edge
                    if (w_expired) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else if (PC_Write) begin
                        r_pc <= Output_Addr;
                        if (Output_Addr == r_end_addr) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= c_DW'(DRAIN_CYCLES);
                        end
                    end
                end
                DRAIN: begin
                    // Only advancing edges count, so a stalled last instruction lengthens the drain
                    if (w_expired) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else if (PC_Write) begin
                        if (r_drain_cnt == c_DW'(1)) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - c_DW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Pure state decode: keeps the hazard unit's PC_Write out of the fetch path
    assign Input_Addr = (r_state == RUN) ? r_pc : NOP_ADDR;
    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;

    sat_counter #(.WIDTH(32)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_accept),
        .inc   (w_active),
        .count (cycle_count)
    );

    sat_counter #(.WIDTH(32)) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_accept),
        .inc   ((r_state == RUN) && PC_Write),
        .count (instr_count)
    );

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_accept),
        .inc   (w_active && !PC_Write),
        .count (stall_count)
    );

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Directed self-checking bench for pc_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] c_NOP = 32'h0000_03FC;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] end_addr;
    logic        PC_Write;
    logic [31:0] Output_Addr;
    logic [31:0] Input_Addr;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic [31:0] stall_count;

    int          n_assert;
    int          n_fail;
    logic [31:0] exp_seq [16];

    pc_sequencer #(
        .ADDR_W       (32),
        .NOP_ADDR     (c_NOP),
        .DRAIN_CYCLES (4),
        .MAX_CYCLES   (32'd10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .end_addr    (end_addr),
        .PC_Write    (PC_Write),
        .Output_Addr (Output_Addr),
        .Input_Addr  (Input_Addr),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .instr_count (instr_count),
        .stall_count (stall_count)
    );

    // The core returns PC+4 of whatever it was handed
    assign Output_Addr = Input_Addr + 32'd4;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) exp_seq[i] = c_NOP;
    endtask

    // stall_mask bit k drops PC_Write for edge k after the start-accepting edge 0
    task automatic run_prog(input string name, input logic [31:0] base, input logic [31:0] last,
                            input logic [31:0] stall_mask, input int exp_edges,
                            input int exp_instr, input int exp_stall, input logic exp_to);
        logic [31:0] seen [32];
        int          n_seen;
        bit          finished;
        base_addr = base;
        end_addr  = last;
        start     = 1'b1;
        PC_Write  = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        n_seen   = 0;
        finished = 1'b0;
        check({name, "_busy_run"}, {31'b0, busy}, 32'd1);
        check({name, "_cycle_clr"}, cycle_count, 32'd0);
        for (int k = 1; k <= 30 && !finished; k++) begin
            PC_Write = !stall_mask[k];
            if (k == 2) begin
                // A start while busy must be ignored (would be an empty program)
                start     = 1'b1;
                base_addr = 32'h100;
                end_addr  = 32'h100;
            end
            seen[n_seen] = Input_Addr;
            n_seen++;
            @(posedge clk); #1;
            start = 1'b0;
            if (done) finished = 1'b1;
        end
        check({name, "_done"}, {31'b0, done}, 32'd1);
        check({name, "_edges"}, n_seen, exp_edges);
        for (int i = 0; i < exp_edges && i < n_seen && i < 16; i++)
            check($sformatf("%s_fetch%0d", name, i), seen[i], exp_seq[i]);
        check({name, "_cycle"}, cycle_count, exp_edges);
        check({name, "_instr"}, instr_count, exp_instr);
        check({name, "_stall"}, stall_count, exp_stall);
        check({name, "_timeout"}, {31'b0, timeout}, {31'b0, exp_to});
        check({name, "_busy_done"}, {31'b0, busy}, 32'd0);
        check({name, "_addr_done"}, Input_Addr, c_NOP);
        PC_Write = 1'b1;
        @(posedge clk); #1;
        check({name, "_frozen"}, cycle_count, exp_edges);
        check({name, "_done_hold"}, {31'b0, done}, 32'd1);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        end_addr  = '0;
        PC_Write  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr",    Input_Addr, c_NOP);
        check("rst_busy",    {31'b0, busy}, 32'd0);
        check("rst_done",    {31'b0, done}, 32'd0);
        check("rst_timeout", {31'b0, timeout}, 32'd0);
        check("rst_cycle",   cycle_count, 32'd0);
        check("rst_instr",   instr_count, 32'd0);
        check("rst_stall",   stall_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 3 instructions, no stalls: 0,4,8 then 4 NOPs, done at edge 7
        fill_nop();
        exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8;
        run_prog("nostall", 32'h0, 32'hC, 32'h0, 7, 3, 0, 1'b0);

        // Stall at edge 2 while pc=4: 0x04 presented twice
        fill_nop();
        exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h4; exp_seq[3] = 32'h8;
        run_prog("runstall", 32'h0, 32'hC, 32'h1 << 2, 8, 3, 1, 1'b0);

        // Stall on the first drain cycle (edge 4): drain spans 5 cycles
        fill_nop();
        exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8;
        run_prog("drainstall", 32'h0, 32'hC, 32'h1 << 4, 8, 3, 1, 1'b0);

        // Empty program; low address bits are discarded so both become 0x40
        fill_nop();
        run_prog("empty", 32'h43, 32'h40, 32'h0, 4, 0, 0, 1'b0);

        // PC_Write held low: budget of 10 cycles expires
        fill_nop();
        for (int i = 0; i < 10; i++) exp_seq[i] = 32'h0;
        run_prog("timeout", 32'h0, 32'hC, 32'hFFFF_FFFF, 10, 0, 10, 1'b1);

        // Asynchronous reset in the middle of a run
        base_addr = 32'h0;
        end_addr  = 32'h20;
        start     = 1'b1;
        PC_Write  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("mid_busy_pre", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  {31'b0, busy}, 32'd0);
        check("mid_rst_addr",  Input_Addr, c_NOP);
        check("mid_rst_cycle", cycle_count, 32'd0);
        check("mid_rst_instr", instr_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        fill_nop();
        exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8;
        run_prog("after_rst", 32'h0, 32'hC, 32'h0, 7, 3, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that drives the five-stage pipelined CPU core's fetch port from the testbench/top level. It owns the PC register and advances it only when the core asserts `PC_Write`. It runs a program from `base_addr` up to, but not including, `end_addr`, then feeds NOP fetches until the pipeline has drained. It reports done, timeout and performance counters.

## Interface
Parameters:
- `ADDR_W`, 32, address width; equals the core's instruction-address width.
- `NOP_ADDR`, 32'h0000_03FC, word address in instruction memory that holds 32'h0; fetched whenever no program instruction is to issue.
- `DRAIN_CYCLES`, 4, advancing cycles after the last issue (ID, EX, MEM, WB).
- `MAX_CYCLES`, 32'd100000, cycle budget in RUN+DRAIN before timeout.

Ports:
- `clk`  in  1  rising-edge clock shared with the core.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request; honoured only in IDLE or DONE.
- `base_addr`  in  ADDR_W  first instruction address; sampled on accepted `start`; bits [1:0] forced to 0.
- `end_addr`  in  ADDR_W  first address not executed; sampled with `base_addr`; bits [1:0] forced to 0.
- `PC_Write`  in  1  core's fetch-advance/hazard-free indication.
- `Output_Addr`  in  ADDR_W  core's incremented PC (PC+4).
- `Input_Addr`  out  ADDR_W  fetch address to the core.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  high in DONE.
- `timeout`  out  1  valid while `done`; set if the cycle budget expired.
- `cycle_count`  out  32  cycles spent in RUN+DRAIN.
- `instr_count`  out  32  instructions issued (advancing RUN cycles).
- `stall_count`  out  32  RUN+DRAIN cycles with `PC_Write`=0.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `Input_Addr`=`NOP_ADDR`.
  - On `start`, latch the addresses and clear all counters and `timeout`.
  - Go to RUN with `pc`=`base_addr`.
  - If `base_addr`==`end_addr`, go to DRAIN directly with `instr_count`=0.
- RUN: `Input_Addr`=`pc`.
  - On a `PC_Write`=1 edge: `pc`<=`Output_Addr` and `instr_count`++.
  - If `Output_Addr`==latched `end_addr` on that edge, go to DRAIN and load `drain_cnt`=`DRAIN_CYCLES`.
  - On a `PC_Write`=0 edge: `pc` holds and `stall_count`++.
- DRAIN: `Input_Addr`=`NOP_ADDR`.
  - `drain_cnt` decrements only on `PC_Write`=1 edges, so a load-use stall of the last instruction extends the drain.
  - At `drain_cnt`==1 with `PC_Write`=1, go to DONE.
- DONE: `Input_Addr`=`NOP_ADDR`; counters frozen; `start` restarts exactly as from IDLE.
- Timeout: if `cycle_count` reaches `MAX_CYCLES`-1 in RUN or DRAIN, go to DONE and set `timeout`=1. Timeout takes priority over the end-address and drain transitions on the same edge.
- `start` in RUN or DRAIN is ignored.
- Counters saturate at 32'hFFFF_FFFF, with no wrap.
- `PC_Write` is ignored in IDLE and DONE.

## Timing
- Reset values:
  - state IDLE; `Input_Addr`=`NOP_ADDR`; `pc`=0.
  - `busy`=0, `done`=0, `timeout`=0.
  - all counters 0.
- Reset asserted mid-RUN/DRAIN returns to IDLE immediately and asynchronously; counters clear.
- `Input_Addr` is a registered-state decode only. There is no combinational path from `PC_Write` or `Output_Addr` to `Input_Addr`, which avoids a loop through the core's hazard unit.
- `start` accepted at edge N: `Input_Addr`=`base_addr` during cycle N+1.
- `busy`, `done`, `timeout` are registered and change on the edge of the state transition.
- With no stalls and n instructions, `done` rises exactly n+4 edges after the start-accepting edge; `cycle_count`=n+4.
- `cycle_count` increments on every RUN/DRAIN edge, including the exiting edge.

## Structure
- Package `pc_seq_pkg`:
  - state enum `pc_seq_state_t` {IDLE, RUN, DRAIN, DONE}.
  - default `NOP_ADDR`, `DRAIN_CYCLES`, `MAX_CYCLES` constants.
- One sub-module, `sat_counter` (width parameter; `clr`, `inc`, saturating). Instantiated three times for the cycle, instr and stall counters.
- FSM, `pc` and `drain_cnt` live in `pc_sequencer`.

## Test plan
- 3 instructions, no stalls:
  - Stimulus: `base_addr`=0x00, `end_addr`=0x0C, `PC_Write` tied 1.
  - Response: `Input_Addr` sequence 0x00, 0x04, 0x08, then `NOP_ADDR` ×4; `done` after 7 edges; `instr_count`=3, `stall_count`=0, `cycle_count`=7.
- Stall in RUN:
  - Stimulus: same program with `PC_Write`=0 for one cycle while `pc`=0x04.
  - Response: 0x04 presented twice; `stall_count`=1, `cycle_count`=8, `instr_count`=3.
- Stall in DRAIN:
  - Stimulus: `PC_Write`=0 on the first DRAIN cycle.
  - Response: DRAIN lasts 5 cycles; `done` one edge later than the no-stall case.
- Empty program:
  - Stimulus: `base_addr`=`end_addr`=0x40.
  - Response: no fetch of 0x40; DRAIN 4 cycles; `instr_count`=0.
- Timeout:
  - Stimulus: `MAX_CYCLES`=10, `PC_Write` held 0.
  - Response: `done`=1 and `timeout`=1 after 10 cycles; `stall_count`=10.
- Reset mid-RUN:
  - Stimulus: assert `rst` asynchronously in RUN, then issue `start` after release.
  - Response: `busy`=0, `Input_Addr`=`NOP_ADDR`, counters 0; a new `start` after release runs normally.
